// File: rtl/ncl_arb_pkg.sv
// Shared types and helpers for the N-channel free-running request arbiter.
//   arb_state_e   : arbiter FSM states (IDLE, DATA, NULLW)
//   ARB_RR/FIXED  : MODE parameter encodings
//   onehot_to_idx : index of the set bit in a one-hot vector of up to MAX_N bits
package ncl_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_NULLW = 2'd2
   } arb_state_e;

   localparam int unsigned ARB_RR    = 0;
   localparam int unsigned ARB_FIXED = 1;

   localparam int unsigned MAX_N = 32;
   localparam int unsigned IDX_W = 5;

   // OR-reduction of indices; exact for one-hot input, zero for all-zero input.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < int'(MAX_N); i++) begin
         if (oh[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ncl_rr_pick.sv
// Combinational rotating-priority picker.
//   req     : request vector
//   start   : highest-priority index; scan runs upward and wraps N-1 -> 0
//   found_c : at least one request asserted
//   idx_c   : winning index (0 when nothing is found)
module ncl_rr_pick
   import ncl_arb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          found_c,
   output logic [IW-1:0] idx_c
);

   logic [IW:0]   cand;
   logic [IW-1:0] sel;
   logic          hit;
   logic [N-1:0]  gnt;

   // Scan from the furthest offset down so the nearest asserted request wins last.
   always_comb begin
      hit  = 1'b0;
      sel  = '0;
      cand = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         cand = {1'b0, start} + (IW+1)'(i);
         if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
         if (req[IW'(cand)]) begin
            hit = 1'b1;
            sel = IW'(cand);
         end
      end
      gnt     = hit ? (N'(1) << sel) : '0;
      found_c = hit;
      idx_c   = IW'(onehot_to_idx(MAX_N'(gnt)));
   end

endmodule

// File: rtl/ncl_free_arbiter_n.sv
// N-channel arbiter: serialises free-running 4-phase request channels onto one
// one-hot output channel with its own completion handshake.
//   clk, init : clock, synchronous active-high reset
//   req       : per-channel request level (high = DATA, low = NULL)
//   req_comp  : per-channel completion back to the winning producer
//   out       : one-hot grant DATA to the consumer, zero = NULL
//   out_comp  : consumer completion (high = DATA accepted, low = NULL seen)
//   grant_idx : index of current or most recent winner
//   busy      : FSM not in IDLE
//   err       : sticky protocol-error flag
module ncl_free_arbiter_n
   import ncl_arb_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned MODE = 0,
   parameter int unsigned IW   = $clog2(N)
) (
   input  logic          clk,
   input  logic          init,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  req_comp,
   output logic [N-1:0]  out,
   input  logic          out_comp,
   output logic [IW-1:0] grant_idx,
   output logic          busy,
   output logic          err
);

   arb_state_e    state_q, state_d;
   logic [N-1:0]  out_q, out_d;
   logic [N-1:0]  req_comp_q, req_comp_d;
   logic [IW-1:0] grant_idx_q, grant_idx_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;

   logic [IW-1:0] pick_start;
   logic          pick_found;
   logic [IW-1:0] pick_idx;

   // Fixed priority is the rotating picker pinned to start at channel 0.
   assign pick_start = (MODE == ARB_FIXED) ? '0 : rr_ptr_q;

   ncl_rr_pick #(.N(N), .IW(IW)) u_pick (
      .req     (req),
      .start   (pick_start),
      .found_c (pick_found),
      .idx_c   (pick_idx)
   );

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      req_comp_d  = req_comp_q;
      grant_idx_d = grant_idx_q;
      rr_ptr_d    = rr_ptr_q;
      busy_d      = busy_q;
      err_d       = err_q;

      unique case (state_q)
         ST_IDLE: begin
            // Consumer still in DATA: no new grant, flag the protocol violation.
            if (out_comp) begin
               err_d = 1'b1;
            end else if (pick_found) begin
               state_d     = ST_DATA;
               out_d       = N'(1) << pick_idx;
               grant_idx_d = pick_idx;
               busy_d      = 1'b1;
            end
         end
         ST_DATA: begin
            if (!req[grant_idx_q]) err_d = 1'b1;
            if (out_comp) begin
               state_d    = ST_NULLW;
               out_d      = '0;
               req_comp_d = out_q;
            end
         end
         ST_NULLW: begin
            if (!req[grant_idx_q] && !out_comp) begin
               state_d    = ST_IDLE;
               req_comp_d = '0;
               busy_d     = 1'b0;
               if (MODE != ARB_FIXED) begin
                  if (grant_idx_q == IW'(N - 1)) rr_ptr_d = '0;
                  else                           rr_ptr_d = grant_idx_q + IW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (init) begin
         state_q     <= ST_IDLE;
         out_q       <= '0;
         req_comp_q  <= '0;
         grant_idx_q <= '0;
         rr_ptr_q    <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         req_comp_q  <= req_comp_d;
         grant_idx_q <= grant_idx_d;
         rr_ptr_q    <= rr_ptr_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign out       = out_q;
   assign req_comp  = req_comp_q;
   assign grant_idx = grant_idx_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ncl_free_arbiter_n.sv
// Directed bench for ncl_free_arbiter_n: three instances share clk/init.
//   sel 0 : N=4, round-robin     sel 1 : N=4, fixed priority     sel 2 : N=8, round-robin
module tb_ncl_free_arbiter_n;

   logic clk = 1'b0;
   logic init;
   logic [7:0] req_v [3];
   logic       oc_v  [3];

   wire [7:0] out_v [3];
   wire [7:0] rc_v  [3];
   wire [2:0] gi_v  [3];
   wire       busy_v [3];
   wire       err_v  [3];

   wire [3:0] o0, rc0, o1, rc1;
   wire [1:0] g0, g1;
   wire [7:0] o2, rc2;
   wire [2:0] g2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ncl_free_arbiter_n #(.N(4), .MODE(0)) u_rr4 (
      .clk(clk), .init(init), .req(req_v[0][3:0]), .req_comp(rc0), .out(o0),
      .out_comp(oc_v[0]), .grant_idx(g0), .busy(busy_v[0]), .err(err_v[0]));

   ncl_free_arbiter_n #(.N(4), .MODE(1)) u_fx4 (
      .clk(clk), .init(init), .req(req_v[1][3:0]), .req_comp(rc1), .out(o1),
      .out_comp(oc_v[1]), .grant_idx(g1), .busy(busy_v[1]), .err(err_v[1]));

   ncl_free_arbiter_n #(.N(8), .MODE(0)) u_rr8 (
      .clk(clk), .init(init), .req(req_v[2]), .req_comp(rc2), .out(o2),
      .out_comp(oc_v[2]), .grant_idx(g2), .busy(busy_v[2]), .err(err_v[2]));

   assign out_v[0] = {4'b0, o0};
   assign out_v[1] = {4'b0, o1};
   assign out_v[2] = o2;
   assign rc_v[0]  = {4'b0, rc0};
   assign rc_v[1]  = {4'b0, rc1};
   assign rc_v[2]  = rc2;
   assign gi_v[0]  = {1'b0, g0};
   assign gi_v[1]  = {1'b0, g1};
   assign gi_v[2]  = g2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      init = 1'b1;
      for (int s = 0; s < 3; s++) begin
         req_v[s] = '0;
         oc_v[s]  = 1'b0;
      end
      tick();
      init = 1'b0;
   endtask

   // Plays consumer and producer for one full transaction on instance sel.
   task automatic serve(input int sel, input bit reraise, output int idx,
                        output logic [7:0] o, output logic [7:0] rc, output bit tmo);
      tmo = 1'b0;
      idx = 0;
      o   = '0;
      rc  = '0;
      for (int k = 0; k < 20 && out_v[sel] == 8'd0; k++) tick();
      if (out_v[sel] == 8'd0) begin
         tmo = 1'b1;
         return;
      end
      o   = out_v[sel];
      idx = int'(gi_v[sel]);
      oc_v[sel] = 1'b1;
      tick();
      for (int k = 0; k < 20 && rc_v[sel] == 8'd0; k++) tick();
      if (rc_v[sel] == 8'd0) begin
         tmo = 1'b1;
         oc_v[sel] = 1'b0;
         return;
      end
      rc = rc_v[sel];
      req_v[sel][idx] = 1'b0;
      oc_v[sel] = 1'b0;
      tick();
      for (int k = 0; k < 20 && rc_v[sel] != 8'd0; k++) tick();
      if (rc_v[sel] != 8'd0) tmo = 1'b1;
      if (reraise) req_v[sel][idx] = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (out_v[s] !== 8'h00 || rc_v[s] !== 8'h00 || gi_v[s] !== 3'd0 ||
             busy_v[s] !== 1'b0 || err_v[s] !== 1'b0) begin
            errors++;
            $display("FAIL reset[%0d]: out=%b req_comp=%b grant_idx=%0d busy=%b err=%b, required all zero",
                     s, out_v[s], rc_v[s], gi_v[s], busy_v[s], err_v[s]);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      req_v[0] = 8'b0100;
      tick();
      checks++;
      if (out_v[0] !== 8'b0100 || gi_v[0] !== 3'd2 || busy_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: out=%b idx=%0d busy=%b, required out=00000100 idx=2 busy=1",
                  out_v[0], gi_v[0], busy_v[0]);
      end
      oc_v[0] = 1'b1;
      tick();
      checks++;
      if (out_v[0] !== 8'b0 || rc_v[0] !== 8'b0100) begin
         errors++;
         $display("FAIL single_comp: out=%b req_comp=%b, required out=00000000 req_comp=00000100",
                  out_v[0], rc_v[0]);
      end
      req_v[0] = '0;
      oc_v[0]  = 1'b0;
      tick();
      checks++;
      if (rc_v[0] !== 8'b0 || busy_v[0] !== 1'b0 || err_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_release: req_comp=%b busy=%b err=%b, required 00000000/0/0",
                  rc_v[0], busy_v[0], err_v[0]);
      end
   endtask

   task automatic test_round_robin();
      int exp_seq [5] = '{0, 1, 2, 3, 0};
      int idx;
      logic [7:0] o, rc;
      bit tmo;
      logic [3:0] seen;
      do_reset();
      req_v[0] = 8'b1111;
      seen = '0;
      for (int t = 0; t < 5; t++) begin
         serve(0, 1'b1, idx, o, rc, tmo);
         checks++;
         if (tmo || idx != exp_seq[t] || o !== (8'd1 << exp_seq[t]) || rc !== (8'd1 << exp_seq[t])) begin
            errors++;
            $display("FAIL rr_seq[%0d]: timeout=%0d idx=%0d out=%b req_comp=%b, required idx=%0d",
                     t, tmo, idx, o, rc, exp_seq[t]);
         end
         if (t < 4 && !tmo) seen[idx[1:0]] = 1'b1;
      end
      checks++;
      if (seen !== 4'b1111) begin
         errors++;
         $display("FAIL rr_fair: served mask=%b, required 1111", seen);
      end
   endtask

   task automatic test_fixed();
      int idx;
      logic [7:0] o, rc;
      bit tmo;
      do_reset();
      req_v[1] = 8'b1010;
      for (int t = 0; t < 3; t++) begin
         serve(1, 1'b1, idx, o, rc, tmo);
         checks++;
         if (tmo || idx != 1 || o !== 8'b0010 || rc !== 8'b0010) begin
            errors++;
            $display("FAIL fixed[%0d]: timeout=%0d idx=%0d out=%b req_comp=%b, required idx=1 out=req_comp=00000010",
                     t, tmo, idx, o, rc);
         end
      end
   endtask

   task automatic test_wrap();
      int idx;
      logic [7:0] o, rc;
      bit tmo;
      do_reset();
      req_v[2] = 8'b0100_0000;
      serve(2, 1'b0, idx, o, rc, tmo);
      checks++;
      if (tmo || idx != 6 || o !== 8'b0100_0000) begin
         errors++;
         $display("FAIL wrap_prime: timeout=%0d idx=%0d out=%b, required idx=6", tmo, idx, o);
      end
      req_v[2] = 8'b1000_0001;
      serve(2, 1'b0, idx, o, rc, tmo);
      checks++;
      if (tmo || idx != 7 || o !== 8'b1000_0000) begin
         errors++;
         $display("FAIL wrap_first: timeout=%0d idx=%0d out=%b, required idx=7", tmo, idx, o);
      end
      serve(2, 1'b0, idx, o, rc, tmo);
      checks++;
      if (tmo || idx != 0 || o !== 8'b0000_0001) begin
         errors++;
         $display("FAIL wrap_second: timeout=%0d idx=%0d out=%b, required idx=0", tmo, idx, o);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_v[0] = 8'b0100;
      tick();
      checks++;
      if (out_v[0] !== 8'b0100) begin
         errors++;
         $display("FAIL mid_pre: out=%b, required 00000100", out_v[0]);
      end
      init = 1'b1;
      tick();
      init = 1'b0;
      checks++;
      if (out_v[0] !== 8'b0 || rc_v[0] !== 8'b0 || busy_v[0] !== 1'b0 || err_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: out=%b req_comp=%b busy=%b err=%b, required all zero",
                  out_v[0], rc_v[0], busy_v[0], err_v[0]);
      end
      req_v[0] = 8'b1111;
      tick();
      checks++;
      if (out_v[0] !== 8'b0001 || gi_v[0] !== 3'd0) begin
         errors++;
         $display("FAIL mid_regrant: out=%b idx=%0d, required out=00000001 idx=0", out_v[0], gi_v[0]);
      end
   endtask

   task automatic test_errors();
      int idx;
      logic [7:0] o, rc;
      bit tmo;
      do_reset();
      req_v[0] = 8'b0010;
      tick();
      checks++;
      if (out_v[0] !== 8'b0010 || err_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL err_grant: out=%b err=%b, required 00000010/0", out_v[0], err_v[0]);
      end
      req_v[0] = '0;
      tick();
      checks++;
      if (err_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL err_drop: err=%b, required 1", err_v[0]);
      end
      oc_v[0] = 1'b1;
      tick();
      oc_v[0] = 1'b0;
      tick();
      req_v[0] = 8'b0001;
      serve(0, 1'b0, idx, o, rc, tmo);
      checks++;
      if (tmo || idx != 0 || err_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: timeout=%0d idx=%0d err=%b, required idx=0 err=1", tmo, idx, err_v[0]);
      end
      do_reset();
      checks++;
      if (err_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: err=%b, required 0", err_v[0]);
      end
      req_v[0] = 8'b0100;
      oc_v[0]  = 1'b1;
      tick();
      tick();
      checks++;
      if (err_v[0] !== 1'b1 || out_v[0] !== 8'b0 || busy_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL err_idle_comp: err=%b out=%b busy=%b, required err=1 out=0 busy=0",
                  err_v[0], out_v[0], busy_v[0]);
      end
      oc_v[0] = 1'b0;
      tick();
      checks++;
      if (out_v[0] !== 8'b0100 || err_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL err_recover: out=%b err=%b, required out=00000100 err=1", out_v[0], err_v[0]);
      end
   endtask

   initial begin
      init = 1'b1;
      for (int s = 0; s < 3; s++) begin
         req_v[s] = '0;
         oc_v[s]  = 1'b0;
      end
      tick();
      test_reset();
      test_single();
      test_round_robin();
      test_fixed();
      test_wrap();
      test_reset_mid();
      test_errors();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
